// File: rtl/audio_pwm_out.sv
// Audio output stage: valid/ready sample FIFO feeding a 1-bit PWM, one sample per 2^SAMPLE_W clocks.
// Optional macro AUDIO_PWM_SIGMA_DELTA_EN swaps the PWM compare for a first-order sigma-delta.
module audio_pwm_out #(
    parameter int unsigned SAMPLE_W   = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        en_i,
    input  logic [SAMPLE_W-1:0]         sample_data_i,
    input  logic                        sample_valid_i,
    output logic                        sample_ready_o,
    output logic                        sample_tick_o,
    output logic                        pwm_o,
    output logic                        underrun_o,
    output logic                        overflow_o,
    output logic [CNT_W-1:0]            underrun_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam logic [LvlW-1:0]     LvlFull  = LvlW'(FIFO_DEPTH);
    localparam logic [SAMPLE_W-1:0] Midscale = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]     level_q, level_d;
    logic [SAMPLE_W-1:0] cnt_q, cnt_d, duty_q, duty_d;
    logic [CNT_W-1:0]    ucnt_q, ucnt_d;
    logic                pwm_q, pwm_d, tick_q, tick_d, under_q, under_d, over_q, over_d;
    logic                ready, push, pop, boundary, underrun;

`ifdef AUDIO_PWM_SIGMA_DELTA_EN
    localparam logic [SAMPLE_W:0] AccMask = {1'b0, {SAMPLE_W{1'b1}}};
    logic [SAMPLE_W:0] acc_q, acc_d;
`endif

    // Ready depends only on the registered level, never on a same-cycle pop.
    assign ready    = en_i && (level_q != LvlFull);
    assign push     = sample_valid_i && ready;
    assign boundary = en_i && (cnt_q == {SAMPLE_W{1'b1}});
    assign pop      = boundary && (level_q != '0);
    assign underrun = boundary && (level_q == '0);

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        duty_d   = duty_q;
        ucnt_d   = ucnt_q;
        pwm_d    = 1'b0;
        tick_d   = 1'b0;
        under_d  = 1'b0;
        over_d   = 1'b0;
`ifdef AUDIO_PWM_SIGMA_DELTA_EN
        acc_d    = '0;
`endif
        if (!en_i) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            duty_d   = Midscale;
        end else begin
            cnt_d = cnt_q + SAMPLE_W'(1);
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
                duty_d   = mem_q[rd_ptr_q];
            end
            if (push && !pop) begin
                level_d = level_q + LvlW'(1);
            end else if (pop && !push) begin
                level_d = level_q - LvlW'(1);
            end
            if (underrun && (ucnt_q != {CNT_W{1'b1}})) begin
                ucnt_d = ucnt_q + CNT_W'(1);
            end
            tick_d  = boundary;
            under_d = underrun;
            over_d  = sample_valid_i && !ready;
`ifdef AUDIO_PWM_SIGMA_DELTA_EN
            acc_d = (acc_q & AccMask) + {1'b0, duty_q};
            pwm_d = acc_d[SAMPLE_W];
`else
            pwm_d = (cnt_q < duty_q);
`endif
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            duty_q   <= Midscale;
            ucnt_q   <= '0;
            pwm_q    <= 1'b0;
            tick_q   <= 1'b0;
            under_q  <= 1'b0;
            over_q   <= 1'b0;
`ifdef AUDIO_PWM_SIGMA_DELTA_EN
            acc_q    <= '0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            duty_q   <= duty_d;
            ucnt_q   <= ucnt_d;
            pwm_q    <= pwm_d;
            tick_q   <= tick_d;
            under_q  <= under_d;
            over_q   <= over_d;
`ifdef AUDIO_PWM_SIGMA_DELTA_EN
            acc_q    <= acc_d;
`endif
        end
    end

    // Storage needs no reset: validity is tracked entirely by the pointers and level.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_data_i;
        end
    end

    assign sample_ready_o = ready;
    assign sample_tick_o  = tick_q;
    assign pwm_o          = pwm_q;
    assign underrun_o     = under_q;
    assign overflow_o     = over_q;
    assign underrun_cnt_o = ucnt_q;
    assign fifo_level_o   = level_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed self-checking bench for audio_pwm_out (SAMPLE_W=8, FIFO_DEPTH=4, CNT_W=16).
module tb_audio_pwm_out;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [7:0]  sample_data_i;
    logic        sample_valid_i;
    logic        sample_ready_o;
    logic        sample_tick_o;
    logic        pwm_o;
    logic        underrun_o;
    logic        overflow_o;
    logic [15:0] underrun_cnt_o;
    logic [2:0]  fifo_level_o;

    int tests = 0;
    int fails = 0;

    audio_pwm_out #(
        .SAMPLE_W   (8),
        .FIFO_DEPTH (4),
        .CNT_W      (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .sample_data_i  (sample_data_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .sample_tick_o  (sample_tick_o),
        .pwm_o          (pwm_o),
        .underrun_o     (underrun_o),
        .overflow_o     (overflow_o),
        .underrun_cnt_o (underrun_cnt_o),
        .fifo_level_o   (fifo_level_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_tick_o && n < 600);
    endtask

    task automatic measure_frame(output int highs);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (pwm_o) highs++;
        end
    endtask

    task automatic push(input logic [7:0] d);
        sample_valid_i = 1'b1;
        sample_data_i  = d;
        step();
        sample_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_i = 1'b1; en_i = 1'b1; sample_valid_i = 1'b0; sample_data_i = 8'h00;
        step();
        step();
        tests++; if (pwm_o !== 1'b0) begin fails++; $display("FAIL reset_pwm: got %b want 0", pwm_o); end
        tests++; if (sample_tick_o !== 1'b0) begin fails++; $display("FAIL reset_tick: got %b want 0", sample_tick_o); end
        tests++; if (underrun_o !== 1'b0 || overflow_o !== 1'b0) begin fails++;
            $display("FAIL reset_pulses: got under=%b over=%b want 0 0", underrun_o, overflow_o); end
        tests++; if (fifo_level_o !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", fifo_level_o); end
        tests++; if (underrun_cnt_o !== 16'd0) begin fails++; $display("FAIL reset_ucnt: got %0d want 0", underrun_cnt_o); end
        tests++; if (sample_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", sample_ready_o); end
        rst_i = 1'b0;
        wait_tick(n);
        tests++; if (n !== 256) begin fails++; $display("FAIL first_tick_latency: got %0d want 256", n); end
        tests++; if (underrun_o !== 1'b1) begin fails++; $display("FAIL first_underrun: got %b want 1", underrun_o); end
        tests++; if (underrun_cnt_o !== 16'd1) begin fails++; $display("FAIL first_ucnt: got %0d want 1", underrun_cnt_o); end
    endtask

    task automatic test_idle();
        int h;
        for (int f = 0; f < 2; f++) begin
            measure_frame(h);
            tests++; if (h !== 128) begin fails++; $display("FAIL idle_high frame %0d: got %0d want 128", f, h); end
            tests++; if (underrun_o !== 1'b1) begin fails++; $display("FAIL idle_underrun frame %0d: got %b want 1", f, underrun_o); end
        end
        tests++; if (underrun_cnt_o !== 16'd3) begin fails++; $display("FAIL idle_ucnt: got %0d want 3", underrun_cnt_o); end
    endtask

    task automatic test_back_to_back();
        int n;
        int h;
        logic [7:0] exp_h [3];
        exp_h[0] = 8'h00; exp_h[1] = 8'hFF; exp_h[2] = 8'h40;
        push(8'h00);
        push(8'hFF);
        push(8'h40);
        tests++; if (fifo_level_o !== 3'd3) begin fails++; $display("FAIL b2b_level_full: got %0d want 3", fifo_level_o); end
        wait_tick(n);
        tests++; if (n !== 253) begin fails++; $display("FAIL b2b_tick_wait: got %0d want 253", n); end
        tests++; if (underrun_o !== 1'b0 || fifo_level_o !== 3'd2) begin fails++;
            $display("FAIL b2b_pop0: got under=%b level=%0d want 0 2", underrun_o, fifo_level_o); end
        for (int k = 0; k < 3; k++) begin
            measure_frame(h);
            tests++; if (h !== int'(exp_h[k])) begin fails++; $display("FAIL b2b_high %0d: got %0d want %0d", k, h, exp_h[k]); end
            tests++; if (underrun_o !== (k == 2) || fifo_level_o !== 3'(k < 2 ? 1 - k : 0)) begin fails++;
                $display("FAIL b2b_end %0d: got under=%b level=%0d", k, underrun_o, fifo_level_o); end
        end
        tests++; if (underrun_cnt_o !== 16'd4) begin fails++; $display("FAIL b2b_ucnt: got %0d want 4", underrun_cnt_o); end
    endtask

    task automatic test_overflow();
        int n;
        int h;
        for (int k = 0; k < 5; k++) begin
            tests++; if (sample_ready_o !== (k < 4)) begin fails++;
                $display("FAIL ovf_ready %0d: got %b want %b", k, sample_ready_o, (k < 4)); end
            sample_valid_i = 1'b1;
            sample_data_i  = 8'h10 + 8'(k);
            step();
            tests++; if (overflow_o !== (k == 4)) begin fails++;
                $display("FAIL ovf_pulse %0d: got %b want %b", k, overflow_o, (k == 4)); end
        end
        sample_valid_i = 1'b0;
        tests++; if (fifo_level_o !== 3'd4) begin fails++; $display("FAIL ovf_level: got %0d want 4", fifo_level_o); end
        step();
        tests++; if (overflow_o !== 1'b0) begin fails++; $display("FAIL ovf_single: got %b want 0", overflow_o); end
        wait_tick(n);
        for (int k = 0; k < 5; k++) begin
            measure_frame(h);
            tests++; if (h !== 16 + (k < 4 ? k : 3)) begin fails++;
                $display("FAIL ovf_high %0d: got %0d want %0d", k, h, 16 + (k < 4 ? k : 3)); end
        end
        tests++; if (underrun_cnt_o !== 16'd6) begin fails++; $display("FAIL ovf_ucnt: got %0d want 6", underrun_cnt_o); end
    endtask

    task automatic test_boundary_push();
        int h;
        for (int i = 0; i < 255; i++) step();
        push(8'h20);
        tests++; if (sample_tick_o !== 1'b1 || underrun_o !== 1'b1) begin fails++;
            $display("FAIL bnd_underrun: got tick=%b under=%b want 1 1", sample_tick_o, underrun_o); end
        tests++; if (fifo_level_o !== 3'd1) begin fails++; $display("FAIL bnd_level: got %0d want 1", fifo_level_o); end
        measure_frame(h);
        tests++; if (h !== 19) begin fails++; $display("FAIL bnd_held_duty: got %0d want 19", h); end
        tests++; if (underrun_o !== 1'b0 || fifo_level_o !== 3'd0) begin fails++;
            $display("FAIL bnd_pop: got under=%b level=%0d want 0 0", underrun_o, fifo_level_o); end
        measure_frame(h);
        tests++; if (h !== 32) begin fails++; $display("FAIL bnd_new_duty: got %0d want 32", h); end
        tests++; if (underrun_cnt_o !== 16'd8) begin fails++; $display("FAIL bnd_ucnt: got %0d want 8", underrun_cnt_o); end
    endtask

    task automatic test_disable();
        int n;
        int h;
        int bad;
        push(8'h30);
        push(8'h50);
        for (int i = 0; i < 98; i++) step();
        tests++; if (fifo_level_o !== 3'd2) begin fails++; $display("FAIL dis_level_pre: got %0d want 2", fifo_level_o); end
        en_i = 1'b0;
        sample_valid_i = 1'b1;
        sample_data_i  = 8'h77;
        step();
        tests++; if (pwm_o !== 1'b0 || fifo_level_o !== 3'd0) begin fails++;
            $display("FAIL dis_flush: got pwm=%b level=%0d want 0 0", pwm_o, fifo_level_o); end
        tests++; if (sample_ready_o !== 1'b0) begin fails++; $display("FAIL dis_ready: got %b want 0", sample_ready_o); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (pwm_o || sample_tick_o || underrun_o || overflow_o) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL dis_quiet: got %0d active cycles want 0", bad); end
        tests++; if (underrun_cnt_o !== 16'd8) begin fails++; $display("FAIL dis_ucnt_held: got %0d want 8", underrun_cnt_o); end
        sample_valid_i = 1'b0;
        en_i = 1'b1;
        wait_tick(n);
        tests++; if (n !== 256) begin fails++; $display("FAIL reen_tick_latency: got %0d want 256", n); end
        tests++; if (underrun_o !== 1'b1 || underrun_cnt_o !== 16'd9) begin fails++;
            $display("FAIL reen_underrun: got under=%b ucnt=%0d want 1 9", underrun_o, underrun_cnt_o); end
        measure_frame(h);
        tests++; if (h !== 128) begin fails++; $display("FAIL reen_midscale: got %0d want 128", h); end
    endtask

`ifdef AUDIO_PWM_SIGMA_DELTA_EN
    task automatic test_sigma_delta();
        int n;
        int h;
        int bad;
        logic v [256];
        push(8'h40);
        wait_tick(n);
        h = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            v[i] = pwm_o;
            if (pwm_o) h++;
        end
        bad = 0;
        for (int i = 4; i < 256; i++) if (v[i] !== v[i-4]) bad++;
        tests++; if (h !== 64) begin fails++; $display("FAIL sd_ones: got %0d want 64", h); end
        tests++; if (bad !== 0) begin fails++; $display("FAIL sd_period4: got %0d breaks want 0", bad); end
    endtask
`endif

    task automatic test_async_reset();
        int n;
        int h;
        push(8'hA0);
        push(8'hB0);
        n = 0;
        while (!pwm_o && n < 300) begin
            step();
            n++;
        end
        tests++; if (pwm_o !== 1'b1 || fifo_level_o !== 3'd2) begin fails++;
            $display("FAIL ar_pre: got pwm=%b level=%0d want 1 2", pwm_o, fifo_level_o); end
        #2 rst_i = 1'b1;
        #1;
        tests++; if (pwm_o !== 1'b0 || fifo_level_o !== 3'd0 || underrun_cnt_o !== 16'd0) begin fails++;
            $display("FAIL ar_immediate: got pwm=%b level=%0d ucnt=%0d want 0 0 0", pwm_o, fifo_level_o, underrun_cnt_o); end
        tests++; if (sample_tick_o !== 1'b0 || underrun_o !== 1'b0 || overflow_o !== 1'b0) begin fails++;
            $display("FAIL ar_pulses: got tick=%b under=%b over=%b want 0 0 0", sample_tick_o, underrun_o, overflow_o); end
        step();
        rst_i = 1'b0;
        wait_tick(n);
        tests++; if (n !== 256 || underrun_o !== 1'b1) begin fails++;
            $display("FAIL ar_discard: got wait=%0d under=%b want 256 1", n, underrun_o); end
        measure_frame(h);
        tests++; if (h !== 128) begin fails++; $display("FAIL ar_midscale: got %0d want 128", h); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_back_to_back();
        test_overflow();
        test_boundary_push();
        test_disable();
`ifdef AUDIO_PWM_SIGMA_DELTA_EN
        test_sigma_delta();
`endif
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
